// File: rtl/vend_multi.sv
// vend_multi: multi-product token vending FSM with saturating credit, refund, auto-refund timeout and change handshake.
module vend_multi #(
  parameter int NUM_PRODUCTS = 4,
  parameter int TOKEN_W = 8,
  parameter int PRICE_W = 4,
  parameter logic [NUM_PRODUCTS*PRICE_W-1:0] PRICES = {4'd4, 4'd3, 4'd2, 4'd1},
  parameter int MAX_CREDIT = 15,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int SEL_W = $clog2(NUM_PRODUCTS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    token_in,
  input  logic [NUM_PRODUCTS-1:0] button,
  input  logic                    button_refund,
  input  logic                    dispense_done,
  output logic                    dispense,
  output logic [SEL_W-1:0]        product_sel,
  output logic [TOKEN_W-1:0]      credit,
  output logic                    change_valid,
  output logic [TOKEN_W-1:0]      change_tokens,
  output logic                    token_reject,
  output logic                    insufficient
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TOKEN_W-1:0] MAX_C = TOKEN_W'(MAX_CREDIT);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, CREDIT, DISPENSE, CHANGE} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic any_btn, tok_ok, idle_c, at_max;
  logic [SEL_W-1:0] sel;
  logic [TOKEN_W-1:0] price, credit_tok;
  // Lowest-index pressed button wins.
  always_comb begin
    sel = '0;
    price = '0;
    any_btn = 1'b0;
    for (int i = NUM_PRODUCTS - 1; i >= 0; i--) begin
      if (button[i]) begin
        sel = SEL_W'(i);
        price = TOKEN_W'(PRICES[i*PRICE_W +: PRICE_W]);
        any_btn = 1'b1;
      end
    end
  end
  assign at_max = credit == MAX_C;
  assign tok_ok = token_in && !at_max;
  assign credit_tok = credit + TOKEN_W'(tok_ok);
  assign idle_c = !token_in && !any_btn && !button_refund;
  assign cnt_nxt = cnt + CNT_W'(1);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      dispense <= 1'b0;
      product_sel <= '0;
      credit <= '0;
      change_valid <= 1'b0;
      change_tokens <= '0;
      token_reject <= 1'b0;
      insufficient <= 1'b0;
    end else begin
      token_reject <= 1'b0;
      insufficient <= 1'b0;
      change_valid <= 1'b0;
      change_tokens <= '0;
      case (state)
        IDLE: if (token_in) begin
          credit <= TOKEN_W'(1);
          cnt <= '0;
          state <= CREDIT;
        end
        CREDIT: begin
          token_reject <= token_in && at_max;
          cnt <= idle_c ? cnt_nxt : '0;
          if (button_refund || (idle_c && cnt_nxt == TO_LAST)) begin
            change_valid <= 1'b1;
            change_tokens <= credit_tok;
            credit <= '0;
            cnt <= '0;
            state <= CHANGE;
          end else if (any_btn && price <= credit) begin
            product_sel <= sel;
            dispense <= 1'b1;
            credit <= credit_tok - price;
            cnt <= '0;
            state <= DISPENSE;
          end else begin
            insufficient <= any_btn;
            credit <= credit_tok;
          end
        end
        DISPENSE: begin
          token_reject <= token_in;
          if (dispense_done) begin
            dispense <= 1'b0;
            change_valid <= credit != '0;
            change_tokens <= credit;
            credit <= '0;
            state <= credit != '0 ? CHANGE : IDLE;
          end
        end
        default: begin
          token_reject <= token_in;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vend_multi.sv
// tb_vend_multi: table-driven directed checks of vend_multi plus timeout and async-reset sequences.
module tb_vend_multi;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic token_in = 1'b0;
  logic [3:0] button = '0;
  logic button_refund = 1'b0;
  logic dispense_done = 1'b0;
  logic dispense;
  logic [1:0] product_sel;
  logic [7:0] credit;
  logic change_valid;
  logic [7:0] change_tokens;
  logic token_reject;
  logic insufficient;
  int total = 0;
  int bad = 0;

  vend_multi #(.TIMEOUT_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .token_in(token_in), .button(button),
    .button_refund(button_refund), .dispense_done(dispense_done),
    .dispense(dispense), .product_sel(product_sel), .credit(credit),
    .change_valid(change_valid), .change_tokens(change_tokens),
    .token_reject(token_reject), .insufficient(insufficient)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic tok; logic [3:0] btn; logic rf; logic dn;
    logic disp; logic [1:0] sel; logic [7:0] cr; logic cv; logic [7:0] ct; logic tr; logic ins;
  } vec_t;
  vec_t v[$];

  function automatic void add(input int tok, input int btn, input int rf, input int dn,
                              input int disp, input int sel, input int cr, input int cv,
                              input int ct, input int tr, input int ins);
    vec_t e;
    e.tok = 1'(tok); e.btn = 4'(btn); e.rf = 1'(rf); e.dn = 1'(dn);
    e.disp = 1'(disp); e.sel = 2'(sel); e.cr = 8'(cr); e.cv = 1'(cv);
    e.ct = 8'(ct); e.tr = 1'(tr); e.ins = 1'(ins);
    v.push_back(e);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic tok, input logic [3:0] btn, input logic rf, input logic dn);
    token_in = tok; button = btn; button_refund = rf; dispense_done = dn;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    // tok btn rf dn | disp sel cr cv ct tr ins
    add(0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0);
    add(0, 4'b1111, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0);
    add(1, 0, 0, 0,  0, 0, 2, 0, 0, 0, 0);
    add(1, 0, 0, 0,  0, 0, 3, 0, 0, 0, 0);
    add(0, 4'b0100, 0, 0, 1, 2, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0,  1, 2, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) add(1, 0, 0, 0, 0, 0, i, 0, 0, 0, 0);
    add(0, 4'b0001, 0, 0, 1, 0, 4, 0, 0, 0, 0);
    add(1, 4'b1000, 1, 0, 1, 0, 4, 0, 0, 1, 0);
    add(0, 0, 0, 1,  0, 0, 0, 1, 4, 0, 0);
    add(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0);
    add(1, 0, 0, 0,  0, 0, 2, 0, 0, 0, 0);
    add(0, 4'b1000, 0, 0, 0, 0, 2, 0, 0, 0, 1);
    add(0, 0, 1, 0,  0, 0, 0, 1, 2, 0, 0);
    add(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 17; i++) add(1, 0, 0, 0, 0, 0, i > 15 ? 15 : i, 0, 0, i > 15 ? 1 : 0, 0);
    add(0, 0, 1, 0,  0, 0, 0, 1, 15, 0, 0);
    add(1, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0);
    add(1, 0, 0, 0,  0, 0, 2, 0, 0, 0, 0);
    add(1, 4'b0110, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0,  1, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1,  0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0);
    add(1, 4'b0100, 0, 0, 0, 0, 2, 0, 0, 0, 1);
    add(0, 4'b0001, 1, 0, 0, 0, 0, 1, 2, 0, 0);
    add(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);

    #1;
    chk("rst_dispense", int'(dispense), 0);
    chk("rst_credit", int'(credit), 0);
    chk("rst_change_valid", int'(change_valid), 0);
    @(posedge clk);
    #1 reset = 1'b1;

    foreach (v[i]) begin
      drive(v[i].tok, v[i].btn, v[i].rf, v[i].dn);
      chk($sformatf("v%0d_dispense", i), int'(dispense), int'(v[i].disp));
      if (v[i].disp) chk($sformatf("v%0d_sel", i), int'(product_sel), int'(v[i].sel));
      chk($sformatf("v%0d_credit", i), int'(credit), int'(v[i].cr));
      chk($sformatf("v%0d_change_valid", i), int'(change_valid), int'(v[i].cv));
      chk($sformatf("v%0d_change_tokens", i), int'(change_tokens), int'(v[i].ct));
      chk($sformatf("v%0d_token_reject", i), int'(token_reject), int'(v[i].tr));
      chk($sformatf("v%0d_insufficient", i), int'(insufficient), int'(v[i].ins));
    end

    // Auto-refund: change_valid appears in the 10th cycle after the token cycle.
    drive(1'b1, 4'b0, 1'b0, 1'b0);
    n = 1;
    while (!change_valid && n < 20) begin
      chk("to_credit_hold", int'(credit), 1);
      drive(1'b0, 4'b0, 1'b0, 1'b0);
      n++;
    end
    chk("to_cycles", n, 10);
    chk("to_change_valid", int'(change_valid), 1);
    chk("to_change_tokens", int'(change_tokens), 1);
    drive(1'b0, 4'b0, 1'b0, 1'b0);
    chk("to_idle_credit", int'(credit), 0);
    chk("to_pulse_end", int'(change_valid), 0);

    // Asynchronous reset while dispensing.
    drive(1'b1, 4'b0, 1'b0, 1'b0);
    drive(1'b1, 4'b0, 1'b0, 1'b0);
    drive(1'b1, 4'b0, 1'b0, 1'b0);
    drive(1'b0, 4'b0001, 1'b0, 1'b0);
    chk("ar_pre_dispense", int'(dispense), 1);
    chk("ar_pre_credit", int'(credit), 2);
    token_in = 1'b0; button = '0;
    #2 reset = 1'b0;
    #1;
    chk("ar_dispense", int'(dispense), 0);
    chk("ar_credit", int'(credit), 0);
    chk("ar_change_valid", int'(change_valid), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    drive(1'b0, 4'b0, 1'b0, 1'b1);
    chk("ar_post_dispense", int'(dispense), 0);
    chk("ar_post_change_valid", int'(change_valid), 0);
    drive(1'b1, 4'b0, 1'b0, 1'b0);
    chk("ar_post_credit", int'(credit), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vend_multi.md
Name: vend_multi

Overview:
- Parametrised successor of the single-product coffee vending FSM.
- Handles NUM_PRODUCTS products with per-product token prices and a saturating credit counter.
- Adds an explicit refund button, inactivity auto-refund, token rejection, and a one-cycle change handshake.
- Sits between the coin/token acceptor and button panel on one side, and the dispenser mechanism on the other.

Parameters:
- NUM_PRODUCTS, 4, number of product buttons (2..16).
- TOKEN_W, 8, width of the credit and change counters.
- PRICE_W, 4, width of each price field.
- PRICES, {4'd4,4'd3,4'd2,4'd1}, packed prices; product i costs PRICES[i*PRICE_W +: PRICE_W]. Every price must be >= 1.
- MAX_CREDIT, 15, credit saturation point. Must satisfy MAX_CREDIT < 2**TOKEN_W.
- TIMEOUT_CYCLES, 1000, idle cycles in CREDIT before an automatic refund (>= 2).
- SEL_W, $clog2(NUM_PRODUCTS), width of product_sel.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- token_in  in  1  one token per cycle while high.
- button  in  NUM_PRODUCTS  product request; bit i selects product i.
- button_refund  in  1  return all credit.
- dispense_done  in  1  dispenser finished (pulse).
- dispense  out  1  dispenser request; level signal.
- product_sel  out  SEL_W  latched product index; valid while dispense=1.
- credit  out  TOKEN_W  current credit.
- change_valid  out  1  one-cycle pulse; change_tokens is valid this cycle.
- change_tokens  out  TOKEN_W  tokens returned; 0 whenever change_valid=0.
- token_reject  out  1  one-cycle pulse: a token was not accepted.
- insufficient  out  1  one-cycle pulse: a button was pressed with credit below its price.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, credit=0, all outputs 0, timeout counter=0. Reset mid-dispense drops dispense immediately and issues no change.
- All outputs are registered. States are IDLE, CREDIT, DISPENSE, CHANGE.
- IDLE (credit=0): token_in -> credit=1, go to CREDIT. Buttons, refund and dispense_done are ignored.
- CREDIT, priority refund > button > token:
  - button_refund -> go to CHANGE.
  - Otherwise, k = lowest set button index:
    - If PRICES[k] <= credit (the pre-token value): product_sel=k, dispense=1 next cycle, credit = credit + accepted_token - PRICES[k], go to DISPENSE.
    - If PRICES[k] > credit: insufficient pulse, stay in CREDIT.
  - token_in: if credit == MAX_CREDIT, token_reject pulse and credit unchanged; else credit+1. A token is still counted in the same cycle as a purchase or an insufficient press.
  - Timeout counter increments each CREDIT cycle with no token_in, button or refund, and clears on any of them. Reaching TIMEOUT_CYCLES-1 -> go to CHANGE (auto-refund).
- DISPENSE:
  - dispense held at 1 and product_sel held stable.
  - token_in -> token_reject pulse. Buttons and refund are ignored.
  - dispense_done -> dispense=0 next cycle; go to CHANGE if credit > 0, else IDLE.
- CHANGE (exactly one cycle): change_valid=1, change_tokens=credit, credit=0, token_in rejected with token_reject, then go to IDLE.
- Latency:
  - button to dispense rising: 1 cycle.
  - dispense_done to dispense falling and change_valid: 1 cycle.
  - refund to change_valid: 1 cycle.
- Credit arithmetic never wraps: saturates at MAX_CREDIT and never goes below 0.
- dispense_done outside DISPENSE is ignored.

Test Plan:
- Prices 1/2/3/4. Tokens for 3 cycles, then button=4'b0100 (product 2, price 3) -> dispense=1 with product_sel=2 one cycle later and credit=0. dispense_done -> dispense=0, state returns to IDLE, no change_valid.
- 5 tokens, button[0] -> credit=4. dispense_done -> change_valid for 1 cycle with change_tokens=4, credit=0.
- 2 tokens, button[3] -> insufficient pulse, credit stays 2. button_refund -> change_tokens=2 on the next cycle.
- 17 consecutive tokens -> credit=15 and token_reject on tokens 16 and 17. Tokens during DISPENSE also raise token_reject.
- TIMEOUT_CYCLES=10, 1 token then idle -> change_valid with change_tokens=1 exactly 10 cycles after the token cycle.
- Assert reset low while dispense=1 -> dispense, credit and change_valid all 0 without waiting for a clock edge. Release reset -> IDLE.
